// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : MIPS opcode constants, instruction field positions and the
//               immediate-extension mode selector for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int TARGET_MSB = 25;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_LUI  = 2'd2
    } imm_mode_e;

    // Logical immediates are unsigned in MIPS; everything else sign-extends.
    function automatic imm_mode_e imm_mode_of(input logic [5:0] opcode);
        imm_mode_e mode;
        mode = IMM_SEXT;
        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
            mode = IMM_ZEXT;
        end else if (opcode == OP_LUI) begin
            mode = IMM_LUI;
        end
        return mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : NUM_REGS x DATA_W register file, two async read ports, one
//               synchronous write port with write-through bypass; r0 is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int RESET_RF = 1,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_ok;

    assign write_ok = we && (waddr != '0);

    // With RESET_RF the clear wins over a write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst && (RESET_RF != 0)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (write_ok && waddr == raddr1) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (write_ok && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage
// Description : MIPS decode stage: field extraction, register read with
//               bypass, immediate/jump generation, load-use hazard detection
//               and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int RESET_RF = 1,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc4,
    output logic              stall_out,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              ex_memread,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [5:0]        id_opcode,
    output logic [5:0]        id_funct,
    output logic [REG_AW-1:0] id_rs,
    output logic [REG_AW-1:0] id_rt,
    output logic [REG_AW-1:0] id_rd,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_imm,
    output logic [DATA_W-1:0] id_jump_dest,
    output logic [DATA_W-1:0] id_pc4
);

    logic [5:0]               dec_opcode;
    logic [5:0]               dec_funct;
    logic [REG_AW-1:0]        dec_rs;
    logic [REG_AW-1:0]        dec_rt;
    logic [REG_AW-1:0]        dec_rd;
    logic [DATA_W-1:0]        rs_data;
    logic [DATA_W-1:0]        rt_data;
    logic [DATA_W-1:0]        dec_imm;
    logic [DATA_W-1:0]        dec_jump;
    logic signed [15:0]       imm_s16;
    logic signed [31:0]       lui_s32;
    logic signed [DATA_W-1:0] imm_sext;
    logic signed [DATA_W-1:0] imm_lui;
    logic [DATA_W-1:0]        imm_zext;
    logic                     hazard;

    assign dec_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];
    assign dec_funct  = if_instr[FUNCT_MSB:FUNCT_LSB];
    assign dec_rs     = REG_AW'(if_instr[RS_MSB:RS_LSB]);
    assign dec_rt     = REG_AW'(if_instr[RT_MSB:RT_LSB]);
    assign dec_rd     = REG_AW'(if_instr[RD_MSB:RD_LSB]);

    // Signed assignment contexts give the sign extension to DATA_W.
    assign imm_s16  = if_instr[IMM_MSB:0];
    assign lui_s32  = {if_instr[IMM_MSB:0], 16'h0000};
    assign imm_sext = imm_s16;
    assign imm_lui  = lui_s32;
    assign imm_zext = {{(DATA_W-16){1'b0}}, if_instr[IMM_MSB:0]};

    always_comb begin
        dec_imm = imm_sext;
        case (imm_mode_of(dec_opcode))
            IMM_ZEXT: dec_imm = imm_zext;
            IMM_LUI:  dec_imm = imm_lui;
            default:  dec_imm = imm_sext;
        endcase
    end

    assign dec_jump = {if_pc4[DATA_W-1:28], if_instr[TARGET_MSB:0], 2'b00};

    assign hazard = if_valid && id_valid && ex_memread && (id_rt != '0) &&
                    ((id_rt == dec_rs) || (id_rt == dec_rt));

    assign stall_out = !flush && (ex_stall || hazard);

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RESET_RF (RESET_RF),
        .REG_AW   (REG_AW)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (dec_rs),
        .raddr2 (dec_rt),
        .rdata1 (rs_data),
        .rdata2 (rt_data)
    );

    // Bubbles only clear id_valid; the payload is left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid     <= 1'b0;
            id_opcode    <= '0;
            id_funct     <= '0;
            id_rs        <= '0;
            id_rt        <= '0;
            id_rd        <= '0;
            id_rs_data   <= '0;
            id_rt_data   <= '0;
            id_imm       <= '0;
            id_jump_dest <= '0;
            id_pc4       <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (ex_stall) begin
            id_valid <= id_valid;
        end else if (hazard) begin
            id_valid <= 1'b0;
        end else begin
            id_valid     <= if_valid;
            id_opcode    <= dec_opcode;
            id_funct     <= dec_funct;
            id_rs        <= dec_rs;
            id_rt        <= dec_rt;
            id_rd        <= dec_rd;
            id_rs_data   <= rs_data;
            id_rt_data   <= rt_data;
            id_imm       <= dec_imm;
            id_jump_dest <= dec_jump;
            id_pc4       <= if_pc4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode_stage
// Description : Directed self-checking bench for instr_decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        stall_out;
    logic        ex_stall;
    logic        flush;
    logic        ex_memread;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [31:0] id_jump_dest;
    logic [31:0] id_pc4;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc4       (if_pc4),
        .stall_out    (stall_out),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .ex_memread   (ex_memread),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_funct     (id_funct),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_jump_dest (id_jump_dest),
        .id_pc4       (id_pc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc4 = '0;
        ex_stall = 1'b0; flush = 1'b0; ex_memread = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset
        tick(); tick();
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_rs_data", id_rs_data, 32'h0);
        chk("rst_imm", id_imm, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_fields", {8'h0, id_opcode, id_funct, id_rs, id_rt, id_rd}, 32'h0);
        rst = 1'b0;
        if_valid = 1'b1; if_instr = rtype(5'd5, 5'd5, 5'd1, 6'h20); if_pc4 = 32'h4;
        tick();
        chk("r5_after_rst", id_rs_data, 32'h0);
        chk("first_valid", {31'b0, id_valid}, 32'h1);
        chk("first_rd_funct", {id_rd, id_funct}, {5'd1, 6'h20});

        // Register file write, bypass, r0
        if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEADBEEF;
        tick();
        chk("bubble_invalid", {31'b0, id_valid}, 32'h0);
        wb_we = 1'b0; if_valid = 1'b1; if_instr = rtype(5'd8, 5'd0, 5'd2, 6'h20);
        tick();
        chk("r8_read", id_rs_data, 32'hDEADBEEF);
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
        if_instr = rtype(5'd0, 5'd9, 5'd3, 6'h20);
        tick();
        chk("r9_bypass", id_rt_data, 32'h1234);
        wb_addr = 5'd0; wb_data = 32'hFFFF; if_instr = rtype(5'd0, 5'd0, 5'd4, 6'h20);
        tick();
        chk("r0_rs_zero", id_rs_data, 32'h0);
        chk("r0_rt_zero", id_rt_data, 32'h0);
        wb_we = 1'b0; if_instr = rtype(5'd9, 5'd8, 5'd4, 6'h20);
        tick();
        chk("r9_stored", id_rs_data, 32'h1234);
        chk("r8_stored_rt", id_rt_data, 32'hDEADBEEF);

        // Immediates and jump target
        if_instr = itype(6'h08, 5'd0, 5'd1, 16'h8000);
        tick();
        chk("addi_sext", id_imm, 32'hFFFF8000);
        chk("addi_opcode", {26'b0, id_opcode}, 32'h08);
        if_instr = itype(6'h0D, 5'd0, 5'd1, 16'h8000);
        tick();
        chk("ori_zext", id_imm, 32'h00008000);
        if_instr = itype(6'h0C, 5'd0, 5'd1, 16'hFFFF);
        tick();
        chk("andi_zext", id_imm, 32'h0000FFFF);
        if_instr = itype(6'h0E, 5'd0, 5'd1, 16'h8001);
        tick();
        chk("xori_zext", id_imm, 32'h00008001);
        if_instr = itype(6'h0F, 5'd0, 5'd1, 16'h1234);
        tick();
        chk("lui_pos", id_imm, 32'h12340000);
        if_instr = itype(6'h0F, 5'd0, 5'd1, 16'h8000);
        tick();
        chk("lui_neg", id_imm, 32'h80000000);
        if_instr = {6'h02, 26'h0000040}; if_pc4 = 32'h40000008;
        tick();
        chk("j_dest", id_jump_dest, 32'h40000100);
        chk("j_pc4", id_pc4, 32'h40000008);

        // Load-use hazard
        if_instr = itype(6'h23, 5'd0, 5'd3, 16'h0000); if_pc4 = 32'h100;
        tick();
        chk("lw_rt", {27'b0, id_rt}, 32'd3);
        ex_memread = 1'b1; if_instr = rtype(5'd3, 5'd4, 5'd5, 6'h20); if_pc4 = 32'h104;
        #1;
        chk("hazard_stall", {31'b0, stall_out}, 32'h1);
        tick();
        chk("hazard_bubble", {31'b0, id_valid}, 32'h0);
        chk("hazard_released", {31'b0, stall_out}, 32'h0);
        tick();
        chk("hazard_issue_valid", {31'b0, id_valid}, 32'h1);
        chk("hazard_issue_rd", {27'b0, id_rd}, 32'd5);
        chk("hazard_issue_pc4", id_pc4, 32'h104);
        // rt match with a load whose rt is 0 is not a hazard
        if_instr = itype(6'h23, 5'd0, 5'd0, 16'h0000);
        tick();
        if_instr = rtype(5'd0, 5'd0, 5'd6, 6'h20);
        #1;
        chk("rt0_no_hazard", {31'b0, stall_out}, 32'h0);
        ex_memread = 1'b0;

        // ex_stall hold, then flush overriding it
        if_instr = rtype(5'd1, 5'd2, 5'd3, 6'h22); if_pc4 = 32'h200;
        tick();
        ex_stall = 1'b1; if_instr = rtype(5'd7, 5'd7, 5'd7, 6'h25); if_pc4 = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("exstall_out", {31'b0, stall_out}, 32'h1);
            tick();
            chk("exstall_hold", {id_valid, 8'h0, id_rd, id_funct, id_pc4[11:0]},
                {1'b1, 8'h0, 5'd3, 6'h22, 12'h200});
        end
        flush = 1'b1;
        #1;
        chk("flush_stall_out", {31'b0, stall_out}, 32'h0);
        tick();
        chk("flush_bubble", {31'b0, id_valid}, 32'h0);
        flush = 1'b0; ex_stall = 1'b0;

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            if_instr = rtype(5'd0, 5'd0, 5'(i + 1), 6'h20);
            if_pc4   = 32'h300 + 32'(4 * i);
            tick();
            chk("stream", {id_valid, 2'b0, id_rd, id_pc4[23:0]},
                {1'b1, 2'b0, 5'(i + 1), 24'h300 + 24'(4 * i)});
        end

        // Reset mid-operation drops a same-cycle write and clears the file
        rst = 1'b1; wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'hCAFE0000;
        tick();
        rst = 1'b0; wb_we = 1'b0;
        chk("midrst_valid", {31'b0, id_valid}, 32'h0);
        chk("midrst_pc4", id_pc4, 32'h0);
        if_instr = rtype(5'd10, 5'd8, 5'd1, 6'h20);
        tick();
        chk("midrst_r10", id_rs_data, 32'h0);
        chk("midrst_r8", id_rt_data, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
